// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmit scheduler and its helpers.
//   tx_state_e : frame sequencer states
//   TXD_IDLE   : level of the serial line between frames (mark)
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic TXD_IDLE = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin selector.
//   valid      [1:0] : requesters asking for service
//   last_grant       : index granted most recently
//   sel        [1:0] : one-hot selection, zero when nothing is valid
// A lone requester always wins; when both ask, the one not served last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] sel
);

  always_comb begin
    sel = valid;
    if (&valid) sel = last_grant ? 2'b01 : 2'b10;
  end

endmodule

// File: rtl/uart_tx_sched.sv
// uart_tx_sched: UART frame transmitter shared by two requesters.
//   clk, reset        : single clock, synchronous active-high reset
//   req_valid [1:0]   : per-requester frame request, held until accepted
//   req_data          : requester i payload at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready [1:0]   : one-hot acceptance, only in IDLE
//   bps_clk           : one-cycle pulse per bit period (external baud ticker)
//   count_enable      : keeps the baud ticker running during a frame
//   txd               : registered serial output, idle high
//   busy              : frame in progress
//   grant_id          : requester owning the current / last frame
// Frame: start(0), data LSB first, optional even parity, stop(1).
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit PARITY_EN  = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [2*DATA_WIDTH-1:0] req_data,
  output logic [1:0]              req_ready,
  input  logic                    bps_clk,
  output logic                    count_enable,
  output logic                    txd,
  output logic                    busy,
  output logic                    grant_id
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  tx_state_e             state, state_nxt;
  logic                  txd_q, txd_nxt;
  logic                  run_q, run_nxt;
  logic [CW-1:0]         cnt_q, cnt_nxt, cnt_inc;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  last_grant, grant_q;
  logic [1:0]            sel;
  logic                  accept;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant),
    .sel        (sel)
  );

  // sel is a subset of req_valid, so any sel bit in IDLE is a transfer
  assign accept  = (state == IDLE) && !reset && (|sel);
  assign cnt_inc = cnt_q + CW'(1);

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      txd_q      <= TXD_IDLE;
      run_q      <= 1'b0;
      cnt_q      <= '0;
      data_q     <= '0;
      grant_q    <= 1'b0;
      last_grant <= 1'b1;          // req 0 preferred after reset
    end else begin
      state <= state_nxt;
      txd_q <= txd_nxt;
      run_q <= run_nxt;
      cnt_q <= cnt_nxt;
      if (accept) begin
        data_q     <= sel[1] ? req_data[DATA_WIDTH +: DATA_WIDTH]
                             : req_data[0 +: DATA_WIDTH];
        grant_q    <= sel[1];
        last_grant <= sel[1];
      end
    end
  end

  // next state: only bps_clk moves the sequencer once a frame has started
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (accept)  state_nxt = START;
      START:  if (bps_clk) state_nxt = DATA;
      DATA:   if (bps_clk && cnt_q == LAST) state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY: if (bps_clk) state_nxt = STOP;
      STOP:   if (bps_clk) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // outputs: handshake plus the next value of the registered line/run bits.
  // Each bit is loaded on the pulse that enters its slot, so it holds for
  // one full bit period.
  always_comb begin
    req_ready = '0;
    txd_nxt   = txd_q;
    run_nxt   = run_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE: begin
        if (!reset) req_ready = sel;
        if (accept) begin
          txd_nxt = 1'b0;
          run_nxt = 1'b1;
        end
      end
      START: if (bps_clk) begin
        txd_nxt = data_q[0];
        cnt_nxt = '0;
      end
      DATA: if (bps_clk) begin
        if (cnt_q == LAST) begin
          txd_nxt = PARITY_EN ? ^data_q : TXD_IDLE;
        end else begin
          txd_nxt = data_q[cnt_inc];
          cnt_nxt = cnt_inc;
        end
      end
      PARITY: if (bps_clk) txd_nxt = TXD_IDLE;
      // leaving STOP lands in IDLE with run low, so the ticker sees at
      // least one disabled cycle before the next acceptance
      STOP: if (bps_clk) begin
        txd_nxt = TXD_IDLE;
        run_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign txd          = txd_q;
  assign busy         = run_q;
  assign count_enable = run_q;
  assign grant_id     = grant_q;

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning payload bits per frame.
REQ-002 SHALL have parameter PARITY_EN, default 0, meaning 1 inserts an even-parity bit after the data bits.
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  2  per-requester frame request, held until accepted.
REQ-006 SHALL have port req_data  input  2*DATA_WIDTH  requester i payload on bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 SHALL have port req_ready  output  2  one-hot acceptance; transfer occurs when req_valid[i] and req_ready[i] are both high on a clk edge.
REQ-008 SHALL have port bps_clk  input  1  one-cycle bit-period pulse from the baud tick generator.
REQ-009 SHALL have port count_enable  output  1  run enable for the baud tick generator.
REQ-010 SHALL have port txd  output  1  serial line, idle high.
REQ-011 SHALL have port busy  output  1  high while a frame is in progress.
REQ-012 SHALL have port grant_id  output  1  index of the requester owning the current or last frame.

Function
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-014 SHALL drive req_ready combinationally: nonzero only in IDLE, one-hot on the arbiter selection, and zero when no req_valid is high.
REQ-015 SHALL arbitrate round-robin: with one valid requester, grant it; with both valid, grant the requester other than last_grant.
REQ-016 SHALL, on acceptance, latch the granted payload, set last_grant and grant_id, drive txd=0, and assert count_enable and busy, all on the same edge; next state is START.
REQ-017 SHALL advance only on bps_clk pulses outside IDLE: START->DATA; DATA shifts LSB first for DATA_WIDTH pulses; then PARITY if PARITY_EN, else STOP; STOP->IDLE.
REQ-018 SHALL hold each bit on txd from one bps_clk pulse until the next; txd is registered.
REQ-019 SHALL drive the parity bit as the XOR of the latched payload bits (even parity).
REQ-020 SHALL deassert count_enable and busy and drive txd=1 on the edge that leaves STOP, and shall not accept in that cycle; count_enable is therefore low for at least one cycle between frames.
REQ-021 SHALL ignore bps_clk in IDLE.
REQ-022 SHALL ignore req_valid and req_data changes outside IDLE.
REQ-023 SHALL size the bit counter as clog2(DATA_WIDTH) bits and terminate exactly at DATA_WIDTH bits, with no wrap into an extra bit.

Reset
REQ-024 SHALL, on reset, including mid-frame, go to IDLE on the next edge with txd=1, count_enable=0, busy=0, grant_id=0, last_grant=1 (req 0 preferred), and shall drive req_ready=0 while reset is high.

Structure
REQ-025 SHALL take the state enumeration and the TXD_IDLE constant from shared package uart_pkg.
REQ-026 SHALL place the two-way round-robin selection in sub-module rr_arb2 (inputs: valid, last_grant; output: one-hot select).

Verification
REQ-027 SHALL verify: DATA_WIDTH=8, PARITY_EN=0, req0 0xA5, bps_clk every 16 clk -> txd 0,1,0,1,0,0,1,0,1,1; req_ready[0] high one cycle; grant_id=0.
REQ-028 SHALL verify: after reset, both valid with req0=0x55 and req1=0x0F, held -> frames sent in order req0, req1, req0; grant_id 0,1,0.
REQ-029 SHALL verify: PARITY_EN=1, payload 0x07 -> 11-bit frame 0,1,1,1,0,0,0,0,0,1,1 (parity=1).
REQ-030 SHALL verify: reset pulsed during the 4th data bit -> next edge txd=1, busy=0, count_enable=0; a later request from req1 alone is granted.
REQ-031 SHALL verify: bps_clk pulses with no req_valid -> txd stays 1, count_enable stays 0, req_ready stays 0.
REQ-032 SHALL verify: back-to-back requests -> count_enable low for at least one cycle between the STOP exit and the next acceptance.
